// File: rtl/chooser_pkg.sv
// Shared types and default parameter values for the function-chooser requester.
package chooser_pkg;

  typedef enum logic [2:0] {
    RELEASE  = 3'd0,
    IDLE     = 3'd1,
    ISSUE    = 3'd2,
    WAIT_FIN = 3'd3,
    GRANT    = 3'd4
  } state_t;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_RST_CYCLES  = 2;
  localparam int DEF_TIMEOUT     = 255;

endpackage

// File: rtl/chooser_fin_catcher.sv
// Captures the chooser's asynchronous, possibly sub-cycle fin pulse and
// synchronizes it into the clk domain as a level (fin_seen) until cleared.
module chooser_fin_catcher #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic chooser_fin,
  input  logic clear,
  output logic fin_seen
);

  logic                   w_catch_rst;
  logic                   r_caught;
  logic [SYNC_STAGES-1:0] r_sync;

  // clear is a registered clk-domain signal, so it is glitch-free as an async clear
  assign w_catch_rst = rst | clear;

  always_ff @(posedge chooser_fin or posedge w_catch_rst) begin
    if (w_catch_rst) r_caught <= 1'b0;
    else             r_caught <= 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_sync <= '0;
    else if (clear) r_sync <= '0;
    else            r_sync <= {r_sync[SYNC_STAGES-2:0], r_caught};
  end

  assign fin_seen = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/chooser_requester.sv
// Clocked initiator for the async function-chooser handshake.
// Optional WAIT_FIN watchdog enabled by defining CHOOSER_TIMEOUT_EN.
//
// state    | meaning
// RELEASE  | chooser_reqs low, chooser_rst pulsed RST_CYCLES cycles, fin catcher held clear
// IDLE     | waiting for any pending request; snapshots pending into issued
// ISSUE    | catcher released; chooser_reqs driven with issued on exit
// WAIT_FIN | holding chooser_reqs until the synchronized fin arrives (or watchdog expires)
// GRANT    | grant_valid high for one cycle; granted bits retired from pending
module chooser_requester
  import chooser_pkg::*;
#(
  parameter int N           = 2,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int RST_CYCLES  = DEF_RST_CYCLES,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req_in,
  output logic [N-1:0] grant,
  output logic         grant_valid,
  output logic         busy,
  output logic [N-1:0] chooser_reqs,
  input  logic [N-1:0] chooser_sets,
  input  logic         chooser_fin,
  output logic         chooser_rst,
  output logic         err
);

  localparam int RCW = $clog2(RST_CYCLES + 1);

  if (SYNC_STAGES < 2 || RST_CYCLES < 1 || TIMEOUT < 1) begin : g_bad_params
    $error("chooser_requester: illegal parameter value");
  end

  state_t         r_state, w_state_nxt;
  logic [N-1:0]   r_pending, w_pending_nxt;
  logic [N-1:0]   r_issued, w_issued_nxt;
  logic [N-1:0]   r_reqs, w_reqs_nxt;
  logic [N-1:0]   r_grant, w_grant_nxt;
  logic           r_grant_valid, w_gv_nxt;
  logic           r_crst, w_crst_nxt;
  logic [RCW-1:0] r_rel_cnt, w_rel_cnt_nxt;
  logic           r_busy;
  logic           r_catch_clr;
  logic           w_fin_seen;
  logic           w_timeout;

  chooser_fin_catcher #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_fin_catcher (
    .clk         (clk),
    .rst         (rst),
    .chooser_fin (chooser_fin),
    .clear       (r_catch_clr),
    .fin_seen    (w_fin_seen)
  );

`ifdef CHOOSER_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;

  logic [TW-1:0] r_to_cnt;
  logic          r_err;

  assign w_timeout = (r_state == WAIT_FIN) && !w_fin_seen && (r_to_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_to_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      if (r_state == ISSUE)
        r_to_cnt <= TW'(TIMEOUT - 1);
      else if (r_state == WAIT_FIN && r_to_cnt != '0)
        r_to_cnt <= r_to_cnt - TW'(1);
      if (w_timeout)
        r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign w_timeout = 1'b0;
  assign err       = 1'b0;
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_pending_nxt = r_pending | req_in;
    w_issued_nxt  = r_issued;
    w_reqs_nxt    = r_reqs;
    w_grant_nxt   = '0;
    w_gv_nxt      = 1'b0;
    w_crst_nxt    = r_crst;
    w_rel_cnt_nxt = r_rel_cnt;
    case (r_state)
      RELEASE: begin
        if (r_rel_cnt != '0) begin
          w_crst_nxt    = 1'b1;
          w_rel_cnt_nxt = r_rel_cnt - RCW'(1);
        end else begin
          w_crst_nxt  = 1'b0;
          w_state_nxt = IDLE;
        end
      end
      IDLE: begin
        if (r_pending != '0) begin
          w_issued_nxt = r_pending;
          w_state_nxt  = ISSUE;
        end
      end
      ISSUE: begin
        w_reqs_nxt  = r_issued;
        w_state_nxt = WAIT_FIN;
      end
      WAIT_FIN: begin
        if (w_fin_seen) begin
          w_grant_nxt = chooser_sets & r_issued;
          w_gv_nxt    = 1'b1;
          w_state_nxt = GRANT;
        end else if (w_timeout) begin
          w_state_nxt   = RELEASE;
          w_reqs_nxt    = '0;
          w_crst_nxt    = 1'b1;
          w_rel_cnt_nxt = RCW'(RST_CYCLES - 1);
        end
      end
      GRANT: begin
        // a same-cycle req_in re-sets the bit just granted, so nothing is lost
        w_pending_nxt = (r_pending & ~r_grant) | req_in;
        w_state_nxt   = RELEASE;
        w_reqs_nxt    = '0;
        w_crst_nxt    = 1'b1;
        w_rel_cnt_nxt = RCW'(RST_CYCLES - 1);
      end
      default: begin
        w_state_nxt = RELEASE;
        w_reqs_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= RELEASE;
      r_pending     <= '0;
      r_issued      <= '0;
      r_reqs        <= '0;
      r_grant       <= '0;
      r_grant_valid <= 1'b0;
      r_crst        <= 1'b0;
      r_rel_cnt     <= RCW'(RST_CYCLES);
      r_busy        <= 1'b0;
      r_catch_clr   <= 1'b1;
    end else begin
      r_state       <= w_state_nxt;
      r_pending     <= w_pending_nxt;
      r_issued      <= w_issued_nxt;
      r_reqs        <= w_reqs_nxt;
      r_grant       <= w_grant_nxt;
      r_grant_valid <= w_gv_nxt;
      r_crst        <= w_crst_nxt;
      r_rel_cnt     <= w_rel_cnt_nxt;
      r_busy        <= (w_state_nxt != IDLE);
      r_catch_clr   <= (w_state_nxt == RELEASE) || (w_state_nxt == IDLE);
    end
  end

  assign grant        = r_grant;
  assign grant_valid  = r_grant_valid;
  assign busy         = r_busy;
  assign chooser_reqs = r_reqs;
  assign chooser_rst  = r_crst;

endmodule

// File: tb/tb_chooser_requester.sv
// Directed bench for chooser_requester: table of request rounds plus reset,
// timeout (CHOOSER_TIMEOUT_EN) and mid-round reset sequences.
module tb_chooser_requester;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req_in = 2'b00;
  logic [1:0] chooser_sets = 2'b00;
  logic       chooser_fin = 1'b0;
  logic [1:0] grant;
  logic       grant_valid;
  logic       busy;
  logic [1:0] chooser_reqs;
  logic       chooser_rst;
  logic       err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  chooser_requester #(
    .N           (2),
    .SYNC_STAGES (2),
    .RST_CYCLES  (2),
    .TIMEOUT     (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_in       (req_in),
    .grant        (grant),
    .grant_valid  (grant_valid),
    .busy         (busy),
    .chooser_reqs (chooser_reqs),
    .chooser_sets (chooser_sets),
    .chooser_fin  (chooser_fin),
    .chooser_rst  (chooser_rst),
    .err          (err)
  );

  typedef struct packed {
    logic [1:0] req;
    logic [1:0] mid;
    logic [1:0] sets;
    logic [1:0] exp_reqs;
    logic [1:0] exp_grant;
    logic       coll;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // call on the first negedge where chooser_rst should be high
  task automatic count_rst_pulse(input string name);
    int rc;
    rc = 0;
    while (chooser_rst === 1'b1 && rc < 10) begin
      rc++;
      @(negedge clk);
    end
    check(name, rc, 2);
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_grant"}, grant, 0);
    check({pfx, "_gv"}, grant_valid, 0);
    check({pfx, "_busy"}, busy, 0);
    check({pfx, "_reqs"}, chooser_reqs, 0);
    check({pfx, "_crst"}, chooser_rst, 0);
    check({pfx, "_err"}, err, 0);
  endtask

  task automatic run_round(input vec_t v, input int idx);
    int w;
    string p;
    p = $sformatf("v%0d", idx);
    w = 0;
    while (busy !== 1'b0 && w < 20) begin
      @(negedge clk);
      w++;
    end
    check({p, "_idle_before"}, busy, 0);
    check({p, "_reqs_low_idle"}, chooser_reqs, 0);
    if (v.req != 2'b00) begin
      req_in = v.req;
      @(negedge clk);
      req_in = 2'b00;
      @(negedge clk);
      check({p, "_reqs_lat_k1"}, chooser_reqs, 0);
      @(negedge clk);
      check({p, "_reqs_lat_k2"}, chooser_reqs, v.exp_reqs);
    end else begin
      w = 0;
      while (chooser_reqs === 2'b00 && w < 10) begin
        @(negedge clk);
        w++;
      end
      check({p, "_reqs_pending"}, chooser_reqs, v.exp_reqs);
    end
    if (v.mid != 2'b00) begin
      req_in = v.mid;
      @(negedge clk);
      req_in = 2'b00;
    end
    chooser_sets = v.sets;
    #1 chooser_fin = 1'b1;
    #3 chooser_fin = 1'b0;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (grant_valid !== 1'b1 && w < 20);
    check({p, "_fin_to_grant"}, w, 3);
    check({p, "_grant"}, grant, v.exp_grant);
    if (v.coll) req_in = v.exp_grant;
    @(negedge clk);
    req_in = 2'b00;
    check({p, "_gv_one_cycle"}, grant_valid, 0);
    check({p, "_reqs_released"}, chooser_reqs, 0);
    count_rst_pulse({p, "_rst_pulse"});
    check({p, "_busy_after"}, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    logic gv_seen;
    //              req    mid    sets   exp_reqs exp_grant coll
    vecs[0] = '{2'b01, 2'b00, 2'b01, 2'b01, 2'b01, 1'b0};
    vecs[1] = '{2'b11, 2'b00, 2'b10, 2'b11, 2'b10, 1'b0};
    vecs[2] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 1'b0};
    vecs[3] = '{2'b01, 2'b00, 2'b01, 2'b01, 2'b01, 1'b1};
    vecs[4] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 1'b0};
    vecs[5] = '{2'b10, 2'b00, 2'b00, 2'b10, 2'b00, 1'b0};
    vecs[6] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b10, 1'b0};
    vecs[7] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 1'b0};
    vecs[8] = '{2'b11, 2'b00, 2'b11, 2'b11, 2'b11, 1'b0};

    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check("release_busy", busy, 1);
    count_rst_pulse("reset_rst_pulse");
    check("reset_idle_busy", busy, 0);

    for (int i = 0; i < 9; i++) run_round(vecs[i], i);

    repeat (5) @(negedge clk);
    check("quiet_busy", busy, 0);
    check("quiet_reqs", chooser_reqs, 0);

`ifdef CHOOSER_TIMEOUT_EN
    req_in = 2'b10;
    @(negedge clk);
    req_in = 2'b00;
    w = 0;
    while (chooser_reqs === 2'b00 && w < 10) begin
      @(negedge clk);
      w++;
    end
    check("to_reqs", chooser_reqs, 2'b10);
    gv_seen = 1'b0;
    w = 0;
    while (chooser_rst !== 1'b1 && w < 40) begin
      @(negedge clk);
      w++;
      if (grant_valid === 1'b1) gv_seen = 1'b1;
    end
    check("to_cycles", w, 16);
    check("to_err", err, 1);
    check("to_no_grant", gv_seen, 0);
    count_rst_pulse("to_rst_pulse");
    run_round('{2'b00, 2'b00, 2'b10, 2'b10, 2'b10, 1'b0}, 90);
    check("to_err_sticky", err, 1);
`else
    gv_seen = 1'b0;
    check("err_tied", err, gv_seen);
`endif

    req_in = 2'b01;
    @(negedge clk);
    req_in = 2'b00;
    w = 0;
    while (chooser_reqs === 2'b00 && w < 10) begin
      @(negedge clk);
      w++;
    end
    check("mid_rst_reqs", chooser_reqs, 2'b01);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_all_zero("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    count_rst_pulse("mid_rst_pulse");
    w = 0;
    repeat (6) begin
      @(negedge clk);
      if (busy !== 1'b0 || chooser_reqs !== 2'b00) w++;
    end
    check("mid_rst_pending_cleared", w, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
